// File: rtl/fir_channel_scheduler_pkg.sv
// Shared definitions for the FIR channel scheduler.
// FSM encodings and default parameter values.
package fir_channel_scheduler_pkg;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_TIMEOUT    = 256;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority arbiter: searches req upward from last_i+1,
// wrapping, and returns the first hit as one-hot and binary id.
module rr_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int CH_WIDTH = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]   req_i,
  input  logic [CH_WIDTH-1:0] last_i,
  output logic [NUM_CH-1:0]   gnt_oh_o,
  output logic [CH_WIDTH-1:0] gnt_id_o,
  output logic                any_req_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_oh_o = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_i) + i) % NUM_CH;
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        gnt_oh_o[idx] = 1'b1;
        gnt_id_o      = CH_WIDTH'(idx);
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/fir_channel_scheduler.sv
// Shares one sequential FIR MAC engine across NUM_CH streams with
// round-robin grants, tagged results and a stall watchdog.
module fir_channel_scheduler
  import fir_channel_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int CH_WIDTH       = $clog2(NUM_CH),
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic [NUM_CH-1:0]            iv_ch_mask,
  input  logic [NUM_CH*DATA_WIDTH-1:0] iv_ch_din,
  input  logic [NUM_CH-1:0]            iv_ch_valid,
  output logic [NUM_CH-1:0]            ov_ch_ready,
  output logic [DATA_WIDTH-1:0]        ov_eng_din,
  output logic [CH_WIDTH-1:0]          ov_eng_bank,
  output logic                         o_eng_din_valid,
  input  logic                         i_eng_ready,
  input  logic [DATA_WIDTH-1:0]        iv_eng_dout,
  input  logic                         i_eng_dout_valid,
  output logic                         o_eng_ready,
  output logic                         o_eng_rst,
  output logic [DATA_WIDTH-1:0]        ov_dout,
  output logic [CH_WIDTH-1:0]          ov_dout_ch,
  output logic                         o_dout_valid,
  input  logic                         i_dout_ready,
  output logic                         o_timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [CH_WIDTH-1:0]   grant_q, grant_d;
  logic [CH_WIDTH-1:0]   last_q, last_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [NUM_CH-1:0]     rdy_q, rdy_d;
  logic                  eng_rdy_q, eng_rdy_d;
  logic                  eng_rst_q, eng_rst_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [CH_WIDTH-1:0]   dout_ch_q, dout_ch_d;
  logic                  dv_q, dv_d;
  logic                  to_q, to_d;
  logic [WD_W-1:0]       wd_q, wd_d;

  logic [NUM_CH-1:0]   req;
  logic [NUM_CH-1:0]   gnt_oh;
  logic [CH_WIDTH-1:0] gnt_id;
  logic                any_req;
  logic                expired;
  logic                fire;

  assign req     = iv_ch_valid & iv_ch_mask;
  assign expired = (wd_q >= WD_LIM);

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .CH_WIDTH (CH_WIDTH)
  ) u_arb (
    .req_i     (req),
    .last_i    (last_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_id_o  (gnt_id),
    .any_req_o (any_req)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    din_d     = din_q;
    rdy_d     = '0;
    eng_rdy_d = 1'b0;
    eng_rst_d = 1'b0;
    dout_d    = dout_q;
    dout_ch_d = dout_ch_q;
    dv_d      = dv_q;
    to_d      = to_q;
    wd_d      = wd_q;
    fire      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_en && any_req) begin
          state_d = ST_ISSUE;
          grant_d = gnt_id;
          rdy_d   = gnt_oh;
          wd_d    = '0;
          for (int k = 0; k < NUM_CH; k++) begin
            if (gnt_oh[k]) din_d = iv_ch_din[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      ST_ISSUE: begin
        wd_d = wd_q + WD_W'(1);
        if (i_eng_ready) state_d = ST_BUSY;
        else if (expired) fire = 1'b1;
      end
      ST_BUSY: begin
        wd_d = wd_q + WD_W'(1);
        if (i_eng_dout_valid) begin
          state_d   = ST_OUT;
          dout_d    = iv_eng_dout;
          dout_ch_d = grant_q;
          dv_d      = 1'b1;
          eng_rdy_d = 1'b1;
        end else if (expired) begin
          fire = 1'b1;
        end
      end
      ST_OUT: begin
        if (i_dout_ready) begin
          state_d = ST_IDLE;
          dv_d    = 1'b0;
          last_d  = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Stall abort: reset the engine and drop the sample.
    if (fire) begin
      state_d   = ST_IDLE;
      eng_rst_d = 1'b1;
      to_d      = 1'b1;
      last_d    = grant_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= CH_WIDTH'(NUM_CH - 1);
      din_q     <= '0;
      rdy_q     <= '0;
      eng_rdy_q <= 1'b0;
      eng_rst_q <= 1'b0;
      dout_q    <= '0;
      dout_ch_q <= '0;
      dv_q      <= 1'b0;
      to_q      <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      din_q     <= din_d;
      rdy_q     <= rdy_d;
      eng_rdy_q <= eng_rdy_d;
      eng_rst_q <= eng_rst_d;
      dout_q    <= dout_d;
      dout_ch_q <= dout_ch_d;
      dv_q      <= dv_d;
      to_q      <= to_d;
      wd_q      <= wd_d;
    end
  end

  assign ov_ch_ready     = rdy_q;
  assign ov_eng_din      = din_q;
  assign ov_eng_bank     = grant_q;
  assign o_eng_din_valid = (state_q == ST_ISSUE);
  assign o_eng_ready     = eng_rdy_q;
  assign o_eng_rst       = eng_rst_q;
  assign ov_dout         = dout_q;
  assign ov_dout_ch      = dout_ch_q;
  assign o_dout_valid    = dv_q;
  assign o_timeout       = to_q;

endmodule
